// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state encoding for the ALU arbiter.
package alu_pkg;

    localparam int unsigned OPW_DEF = 4;

    localparam logic [OPW_DEF-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW_DEF-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW_DEF-1:0] OP_OR   = 4'b0010;
    localparam logic [OPW_DEF-1:0] OP_AND  = 4'b0011;
    localparam logic [OPW_DEF-1:0] OP_NOR  = 4'b0100;
    localparam logic [OPW_DEF-1:0] OP_SLT  = 4'b0101;
    localparam logic [OPW_DEF-1:0] OP_LAST = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit ALU: ADD/SUB/OR/AND/NOR/SLT with N/Z/C/V flags (C,V only for ADD/SUB).
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_op,
    output logic [WIDTH-1:0] o_res_c,
    output logic             o_n_c,
    output logic             o_z_c,
    output logic             o_c_c,
    output logic             o_v_c
);

    logic [WIDTH:0] w_sum;

    // Result and carry/overflow by opcode; SUB carry is the no-borrow carry of a + ~b + 1
    always_comb begin
        w_sum   = '0;
        o_res_c = '0;
        o_c_c   = 1'b0;
        o_v_c   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum   = {1'b0, i_a} + {1'b0, i_b};
                o_res_c = w_sum[WIDTH-1:0];
                o_c_c   = w_sum[WIDTH];
                o_v_c   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);
                o_res_c = w_sum[WIDTH-1:0];
                o_c_c   = w_sum[WIDTH];
                o_v_c   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_OR:  o_res_c = i_a | i_b;
            OP_AND: o_res_c = i_a & i_b;
            OP_NOR: o_res_c = ~(i_a | i_b);
            OP_SLT: o_res_c = WIDTH'($signed(i_a) < $signed(i_b));
            default: o_res_c = '0;
        endcase
    end

    assign o_n_c = o_res_c[WIDTH-1];
    assign o_z_c = (o_res_c == '0);

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: pointer port wins when valid, else the other port.
module rr_arb2 (
    input  logic i_en,
    input  logic i_ptr,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_gnt0_c,
    output logic o_gnt1_c
);

    // Priority follows the pointer; no grant while disabled
    always_comb begin
        o_gnt0_c = 1'b0;
        o_gnt1_c = 1'b0;
        if (i_en) begin
            if (i_ptr == 1'b0) begin
                o_gnt0_c = i_valid0;
                o_gnt1_c = !i_valid0 && i_valid1;
            end else begin
                o_gnt1_c = i_valid1;
                o_gnt0_c = !i_valid1 && i_valid0;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU between two requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN adds the ERR output and illegal-opcode squashing.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [OPW-1:0]   OP0,
    output logic             READY0,
    input  logic             VALID1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [OPW-1:0]   OP1,
    output logic             READY1,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [WIDTH-1:0] RES,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    output logic             ERR
`endif
);

    state_t           r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_res;
    logic             r_n, r_z, r_c, r_v;
    logic             w_gnt0, w_gnt1;
    logic [WIDTH-1:0] w_res;
    logic             w_n, w_z, w_c, w_v;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             r_err;
`endif

    rr_arb2 u_arb (
        .i_en     (r_state == ST_IDLE),
        .i_ptr    (r_ptr),
        .i_valid0 (VALID0),
        .i_valid1 (VALID1),
        .o_gnt0_c (w_gnt0),
        .o_gnt1_c (w_gnt1)
    );

    alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .o_res_c (w_res),
        .o_n_c   (w_n),
        .o_z_c   (w_z),
        .o_c_c   (w_c),
        .o_v_c   (w_v)
    );

    // Sequencer: accept in IDLE, capture ALU result in EXEC, hold response in RESP
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_res       <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0) begin
                        r_a     <= A0;
                        r_b     <= B0;
                        r_op    <= OP0;
                        r_id    <= 1'b0;
                        r_ptr   <= 1'b1;
                        r_state <= ST_EXEC;
                    end else if (w_gnt1) begin
                        r_a     <= A1;
                        r_b     <= B1;
                        r_op    <= OP1;
                        r_id    <= 1'b1;
                        r_ptr   <= 1'b0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    if (r_op > OPW'(OP_LAST)) begin
                        r_res <= '0;
                        r_n   <= 1'b0;
                        r_z   <= 1'b0;
                        r_c   <= 1'b0;
                        r_v   <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_res <= w_res;
                        r_n   <= w_n;
                        r_z   <= w_z;
                        r_c   <= w_c;
                        r_v   <= w_v;
                        r_err <= 1'b0;
                    end
`else
                    r_res <= w_res;
                    r_n   <= w_n;
                    r_z   <= w_z;
                    r_c   <= w_c;
                    r_v   <= w_v;
`endif
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign READY0    = w_gnt0;
    assign READY1    = w_gnt1;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ID    = r_rsp_id;
    assign RES       = r_res;
    assign N         = r_n;
    assign Z         = r_z;
    assign C         = r_c;
    assign V         = r_v;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign ERR       = r_err;
`endif

endmodule
